// File: rtl/sap_register_bank.sv
// SAP datapath register bank: NUM_REGS general registers plus MAR, IR and a counting PC
// behind one select/load/oe interface, with a registered read port and error pulses.
module sap_register_bank #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     load,
    input  logic                     oe,
    input  logic                     pc_inc,
    input  logic                     ir_clr,
    input  logic [DATA_W-1:0]        bus_in,
    output logic [DATA_W-1:0]        bus_out,
    output logic [DATA_W-ADDR_W-1:0] opcode,
    output logic [ADDR_W-1:0]        mar_addr,
    output logic [ADDR_W-1:0]        pc,
    output logic                     pc_wrap,
    output logic                     sel_err
);

    localparam logic [SEL_W-1:0] MAR_SEL   = SEL_W'(NUM_REGS);
    localparam logic [SEL_W-1:0] IR_SEL    = SEL_W'(NUM_REGS + 1);
    localparam logic [SEL_W-1:0] PC_SEL    = SEL_W'(NUM_REGS + 2);
    // One bit wider so the bound still fits when 2^SEL_W == NUM_REGS + 3.
    localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W + 1)'(NUM_REGS + 3);
    localparam int               PAD_W     = DATA_W - ADDR_W;

    logic [DATA_W-1:0] gpr_q [NUM_REGS];
    logic [DATA_W-1:0] gpr_d [NUM_REGS];
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic              pc_wrap_q, pc_wrap_d;
    logic              sel_err_q, sel_err_d;

    logic              sel_valid;
    logic              pc_load;
    logic [DATA_W-1:0] rd_data;

    assign sel_valid = {1'b0, sel} < SEL_LIMIT;
    assign pc_load   = load && (sel == PC_SEL);

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == SEL_W'(i)) begin
                rd_data = gpr_q[i];
            end
        end
        if (sel == MAR_SEL) begin
            rd_data = {{PAD_W{1'b0}}, mar_q};
        end
        if (sel == IR_SEL) begin
            rd_data = {{PAD_W{1'b0}}, ir_q[ADDR_W-1:0]};
        end
        if (sel == PC_SEL) begin
            rd_data = {{PAD_W{1'b0}}, pc_q};
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            gpr_d[i] = gpr_q[i];
            if (load && (sel == SEL_W'(i))) begin
                gpr_d[i] = bus_in;
            end
        end

        mar_d = mar_q;
        if (load && (sel == MAR_SEL)) begin
            mar_d = bus_in[ADDR_W-1:0];
        end

        ir_d = ir_q;
        if (ir_clr) begin
            ir_d = '0;
        end else if (load && (sel == IR_SEL)) begin
            ir_d = bus_in;
        end

        pc_d      = pc_q;
        pc_wrap_d = 1'b0;
        if (pc_load) begin
            pc_d = bus_in[ADDR_W-1:0];
        end else if (pc_inc) begin
            pc_d      = pc_q + ADDR_W'(1);
            pc_wrap_d = (pc_q == '1);
        end

        bus_out_d = oe ? rd_data : '0;
        sel_err_d = (load || oe) && !sel_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= '0;
            end
            mar_q     <= '0;
            ir_q      <= '0;
            pc_q      <= '0;
            bus_out_q <= '0;
            pc_wrap_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            mar_q     <= mar_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            bus_out_q <= bus_out_d;
            pc_wrap_q <= pc_wrap_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus_out  = bus_out_q;
    assign opcode   = ir_q[DATA_W-1:ADDR_W];
    assign mar_addr = mar_q;
    assign pc       = pc_q;
    assign pc_wrap  = pc_wrap_q;
    assign sel_err  = sel_err_q;

endmodule
